// File: rtl/lcd_bus_scheduler_if.sv
// Requester handshake and LCD pin bundle for lcd_bus_scheduler.
// slave = scheduler side, master = requesters/pins side.
interface lcd_bus_scheduler_if #(
    parameter int unsigned NUM_REQ = 2
);
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ-1:0]   req_rs;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   gnt;
    logic                 busy;
    logic [1:0]           owner;
    logic                 rs;
    logic                 rw;
    logic                 en;
    logic [7:0]           data;

    modport slave (
        input  req, req_rs, req_data, req_last,
        output gnt, busy, owner, rs, rw, en, data
    );

    modport master (
        output req, req_rs, req_data, req_last,
        input  gnt, busy, owner, rs, rw, en, data
    );
endinterface

// File: rtl/lcd_bus_scheduler.sv
// Round-robin, string-locked arbiter for a shared HD44780 8-bit bus; owns setup,
// enable-pulse and execution-delay timing. Define LCD_INIT_EN for a power-up init sequence.
module lcd_bus_scheduler #(
    parameter int unsigned NUM_REQ            = 2,
    parameter int unsigned EN_PULSE_CYCLES    = 25,
    parameter int unsigned CMD_DELAY_CYCLES   = 50000,
    parameter int unsigned CLEAR_DELAY_CYCLES = 100000
) (
    input  logic               clk,
    input  logic               reset,
    lcd_bus_scheduler_if.slave bus
);
    localparam int unsigned MAX_DLY = (CLEAR_DELAY_CYCLES > CMD_DELAY_CYCLES) ?
                                      CLEAR_DELAY_CYCLES : CMD_DELAY_CYCLES;
    localparam int unsigned MAX_CNT = (MAX_DLY > EN_PULSE_CYCLES) ? MAX_DLY : EN_PULSE_CYCLES;
    localparam int unsigned CNT_W   = ($clog2(MAX_CNT + 1) > 17) ? $clog2(MAX_CNT + 1) : 17;
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned SUM_W   = IDX_W + 1;

    typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, INIT} state_t;

`ifdef LCD_INIT_EN
    localparam state_t RST_STATE = INIT;
`else
    localparam state_t RST_STATE = IDLE;
`endif

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic               lock_q, lock_d;
    logic               rs_q, rs_d;
    logic [7:0]         data_q, data_d;
    logic               en_q, en_d;
    logic               busy_q, busy_d;
`ifdef LCD_INIT_EN
    logic [1:0]         init_idx_q, init_idx_d;
    logic               init_act_q, init_act_d;
`endif

    logic [NUM_REQ-1:0] own_oh, elig, rot, gnt_c;
    logic [SUM_W-1:0]   sum;
    logic [IDX_W-1:0]   win;
    logic               found, grant, win_rs, win_last, is_clear;
    logic [7:0]         win_data;
    logic [CNT_W-1:0]   hold_len;

    // Rotate eligible requests so the rr pointer sits at bit 0, take the lowest set bit.
    always_comb begin
        own_oh = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            own_oh[i] = (owner_q == IDX_W'(i));
        end
        elig  = lock_q ? (bus.req & own_oh) : bus.req;
        rot   = NUM_REQ'({elig, elig} >> rr_q);
        found = |rot;
        sum   = '0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (rot[i]) sum = SUM_W'(rr_q) + SUM_W'(i);
        end
        win = (sum >= SUM_W'(NUM_REQ)) ? IDX_W'(sum - SUM_W'(NUM_REQ)) : IDX_W'(sum);
        grant = found && (state_q == IDLE) && !reset;

        win_rs   = 1'b0;
        win_last = 1'b0;
        win_data = '0;
        gnt_c    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win == IDX_W'(i)) begin
                win_rs   = bus.req_rs[i];
                win_last = bus.req_last[i];
                win_data = bus.req_data[8*i +: 8];
                gnt_c[i] = grant;
            end
        end
    end

    assign is_clear = !rs_q && ((data_q == 8'h01) || (data_q == 8'h02));
    assign hold_len = is_clear ? CNT_W'(CLEAR_DELAY_CYCLES - 1) : CNT_W'(CMD_DELAY_CYCLES - 1);

`ifdef LCD_INIT_EN
    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction
`endif

    // Next-state and registered-output values.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        lock_d  = lock_q;
        rs_d    = rs_q;
        data_d  = data_q;
`ifdef LCD_INIT_EN
        init_idx_d = init_idx_q;
        init_act_d = init_act_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    owner_d = win;
                    rs_d    = win_rs;
                    data_d  = win_data;
                    lock_d  = !win_last;
                    if (win_last) begin
                        rr_d = (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + IDX_W'(1);
                    end
                    state_d = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = CNT_W'(EN_PULSE_CYCLES - 1);
                state_d = PULSE;
            end
            PULSE: begin
                if (cnt_q == '0) begin
                    cnt_d   = hold_len;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
`ifdef LCD_INIT_EN
                    // init_idx wraps to 0 once the last init command has been issued
                    if (init_act_q && (init_idx_q != 2'd0)) begin
                        state_d = INIT;
                    end else begin
                        state_d    = IDLE;
                        init_act_d = 1'b0;
                    end
`else
                    state_d = IDLE;
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`ifdef LCD_INIT_EN
            INIT: begin
                rs_d       = 1'b0;
                data_d     = init_cmd(init_idx_q);
                init_idx_d = init_idx_q + 2'd1;
                state_d    = SETUP;
            end
`endif
            default: state_d = IDLE;
        endcase
        en_d   = (state_d == PULSE);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
            rr_q    <= '0;
            owner_q <= '0;
            lock_q  <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
`ifdef LCD_INIT_EN
            init_idx_q <= 2'd0;
            init_act_q <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            lock_q  <= lock_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
`ifdef LCD_INIT_EN
            init_idx_q <= init_idx_d;
            init_act_q <= init_act_d;
`endif
        end
    end

    assign bus.gnt   = gnt_c;
    assign bus.busy  = busy_q;
    assign bus.owner = owner_q;
    assign bus.rs    = rs_q;
    assign bus.rw    = 1'b0;
    assign bus.en    = en_q;
    assign bus.data  = data_q;
endmodule
